// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MEM_RD_BIT = 1;
  localparam int unsigned MEM_WR_BIT = 0;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  function automatic logic is_access(input logic [1:0] mem);
    return mem[MEM_RD_BIT] | mem[MEM_WR_BIT];
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts BUSY cycles and flags when the memory has gone TIMEOUT_CYCLES without ack.
// Only present when MEM_ACCESS_TIMEOUT_EN is defined.
`ifdef MEM_ACCESS_TIMEOUT_EN
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic busy,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // cnt holds the index of the current BUSY cycle, starting at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (busy && (cnt != CNT_W'(TIMEOUT_CYCLES))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired_c = busy && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mem_access_ctrl.sv
// MEM-stage req/ack bridge to a variable-latency data memory; stalls the pipe until done.
// Define MEM_ACCESS_TIMEOUT_EN to add a BUSY timeout abort and the mem_timeout pulse.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
`ifdef MEM_ACCESS_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        MEM_M,
  input  logic [ADDR_W-1:0] ALUOut_M,
  input  logic [DATA_W-1:0] WriteData_M,
  output logic              StallM,
  output logic [DATA_W-1:0] ReadData_M,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              misaligned
`ifdef MEM_ACCESS_TIMEOUT_EN
  , output logic            mem_timeout
`endif
);

  state_e            state, state_d;
  logic              req_d, we_d, mis_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, rdata_d;
  logic              access;

  assign access = is_access(MEM_M);

  // Gated by rst_n so the pipeline is released the moment reset asserts
  assign StallM = rst_n && (((state == IDLE) && access) || (state == BUSY));

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic expired_c;
  logic tmo_d;

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state != BUSY),
    .busy     (state == BUSY),
    .expired_c(expired_c)
  );
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    rdata_d = ReadData_M;
    mis_d   = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    tmo_d   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (access) begin
          req_d   = 1'b1;
          we_d    = MEM_M[MEM_WR_BIT];
          addr_d  = {ALUOut_M[ADDR_W-1:2], 2'b00};
          wdata_d = WriteData_M;
          mis_d   = |ALUOut_M[1:0];
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          if (!mem_we) rdata_d = mem_rdata;
          state_d = DONE;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (expired_c) begin
          req_d   = 1'b0;
          if (!mem_we) rdata_d = DATA_W'(TIMEOUT_DATA);
          tmo_d   = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ReadData_M <= '0;
      misaligned <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      mem_timeout <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      mem_req    <= req_d;
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
      ReadData_M <= rdata_d;
      misaligned <= mis_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
      mem_timeout <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus random transactions vs a transaction model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  MEM_M;
  logic [31:0] ALUOut_M;
  logic [31:0] WriteData_M;
  logic        StallM;
  logic [31:0] ReadData_M;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        misaligned;
`ifdef MEM_ACCESS_TIMEOUT_EN
  logic        mem_timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MEM_M      (MEM_M),
    .ALUOut_M   (ALUOut_M),
    .WriteData_M(WriteData_M),
    .StallM     (StallM),
    .ReadData_M (ReadData_M),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .misaligned (misaligned)
`ifdef MEM_ACCESS_TIMEOUT_EN
    , .mem_timeout(mem_timeout)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: memory acks after `waits` extra BUSY cycles.
  task automatic run_access(input logic [1:0] m, input logic [31:0] a, input logic [31:0] wd,
                            input int waits, input logic [31:0] rd);
    logic        exp_we;
    logic [31:0] exp_addr;
    int          stall_cnt;
    exp_we    = m[0];
    exp_addr  = a & 32'hFFFF_FFFC;
    stall_cnt = 0;
    MEM_M = m; ALUOut_M = a; WriteData_M = wd;
    #1;
    check("stall_issue", StallM, 1);
    if (StallM) stall_cnt++;
    tick();
    check("req_on", mem_req, 1);
    check("we", mem_we, exp_we);
    check("addr", mem_addr, exp_addr);
    if (exp_we) check("wdata", mem_wdata, wd);
    check("misaligned", misaligned, a[1:0] != 2'b00);
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        mem_ack = 1'b1; mem_rdata = rd;
      end
      #1;
      if (StallM) stall_cnt++;
      if (i > 0) begin
        check("req_hold", mem_req, 1);
        check("addr_hold", mem_addr, exp_addr);
        if (exp_we) check("wdata_hold", mem_wdata, wd);
        check("mis_once", misaligned, 0);
      end
      tick();
      mem_ack = 1'b0; mem_rdata = $urandom;
    end
    if (!exp_we) exp_rdata = rd;
    // DONE: random inputs and a stray ack must be ignored
    MEM_M = 2'($urandom); ALUOut_M = $urandom; mem_ack = 1'($urandom); mem_rdata = $urandom;
    #1;
    check("stall_done", StallM, 0);
    check("req_done", mem_req, 0);
    check("rdata", ReadData_M, exp_rdata);
    check("stall_cycles", 64'(stall_cnt), 64'(waits + 2));
    tick();
    mem_ack = 1'b0; MEM_M = 2'b00;
    #1;
    check("idle_after_done", mem_req, 0);
    check("rdata_hold", ReadData_M, exp_rdata);
  endtask

  task automatic idle_with_stray_ack();
    MEM_M = 2'b00; mem_ack = 1'b1; mem_rdata = $urandom;
    #1;
    check("idle_stall", StallM, 0);
    tick();
    mem_ack = 1'b0;
    check("idle_req", mem_req, 0);
    check("idle_rdata", ReadData_M, exp_rdata);
  endtask

  initial begin
    rst_n = 1'b0; MEM_M = 2'b00; ALUOut_M = '0; WriteData_M = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #12;
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", ReadData_M, 0);
    check("rst_mis", misaligned, 0);
    check("rst_stall", StallM, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_access(2'b10, 32'h100, 32'h0, 0, 32'h1234_5678);
    run_access(2'b01, 32'h204, 32'hCAFE_F00D, 2, 32'h5555_AAAA);
    run_access(2'b11, 32'h103, 32'h0BAD_CAFE, 1, 32'h0);
    idle_with_stray_ack();
    run_access(2'b10, 32'h10, 32'h0, 0, 32'hA);
    run_access(2'b10, 32'h14, 32'h0, 1, 32'hB);
    check("b2b_final", ReadData_M, 32'hB);

    // Reset while BUSY: drop request at once, ignore late ack
    MEM_M = 2'b10; ALUOut_M = 32'h40;
    tick();
    check("pre_rst_req", mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", mem_req, 0);
    check("rst_mid_stall", StallM, 0);
    check("rst_mid_rdata", ReadData_M, 0);
    exp_rdata = '0;
    MEM_M = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0;
    check("late_ack_req", mem_req, 0);
    check("late_ack_rdata", ReadData_M, 0);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) idle_with_stray_ack();
      run_access(2'($urandom_range(1, 3)), $urandom, $urandom, $urandom_range(0, 5), $urandom);
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    begin
      int busy_cycles;
      busy_cycles = 0;
      MEM_M = 2'b10; ALUOut_M = 32'h300;
      tick();
      MEM_M = 2'b00;
      while (mem_req && busy_cycles < 100) begin
        busy_cycles++;
        check("tmo_quiet", mem_timeout, 0);
        tick();
      end
      check("tmo_busy_cycles", 64'(busy_cycles), 64'd16);
      check("tmo_pulse", mem_timeout, 1);
      check("tmo_rdata", ReadData_M, 32'hDEAD_BEEF);
      exp_rdata = 32'hDEAD_BEEF;
      tick();
      check("tmo_pulse_end", mem_timeout, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
